// File: rtl/seq_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_scan_pkg
// Description : Shared types and helpers for the programmable serial pattern
//               scan controller (seq_scan_ctrl / seq_pat_match).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_scan_pkg;

    localparam int PAT_MAX_DEF = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int TMO_W_DEF   = 16;

    // Run sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Force a requested pattern length into the legal range 1..pat_max
    function automatic int clamp_len(input int len, input int pat_max);
        if (len < 1) begin
            return 1;
        end else if (len > pat_max) begin
            return pat_max;
        end else begin
            return len;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pat_match.sv
`default_nettype none
// ============================================================================
// Module      : seq_pat_match
// Description : Serial history shifter with fill counter and length-masked
//               pattern compare. hit is combinational and describes the
//               sample being shifted in this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pat_match
    import seq_scan_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic               clr,
    input  logic               x,
    input  logic [LEN_W-1:0]   len,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic               overlap,
    output logic               hit
);

    logic [PAT_MAX-1:0] hist_q, hist_d, w_hist_next;
    logic [LEN_W-1:0]   fill_q, fill_d, w_fill_next;
    logic [PAT_MAX-1:0] w_mask;

    // Newest bit enters at bit 0
    generate
        if (PAT_MAX > 1) begin : g_hist_wide
            assign w_hist_next = {hist_q[PAT_MAX-2:0], x};
        end else begin : g_hist_one
            assign w_hist_next = x;
        end
    endgenerate

    // Fill saturates once the whole history holds valid bits
    assign w_fill_next = (fill_q >= LEN_W'(PAT_MAX)) ? fill_q : fill_q + 1'b1;

    // Only the low len bits take part in the compare
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            w_mask[i] = (i < 32'(len));
        end
    end

    assign hit = shift && (w_fill_next >= len) &&
                 ((w_hist_next & w_mask) == (pattern & w_mask));

    // Next history/fill: clear on arm, restart fill after a non-overlapping hit
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift) begin
            hist_d = w_hist_next;
            fill_d = (hit && !overlap) ? '0 : w_fill_next;
        end
    end

    // History and fill registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_scan_ctrl
// Description : Arms and sequences a programmable serial pattern detector,
//               counts matches and ends a run on target count or timeout.
//               Optional macro SEQ_SCAN_TSTAMP_EN adds first_ts, the number
//               of qualified samples from start up to the first hit.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_W   = TMO_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PAT_MAX-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic [TMO_W-1:0]             cfg_timeout,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         x,
    input  logic                         x_valid,
    output logic                         busy,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         done,
`ifdef SEQ_SCAN_TSTAMP_EN
    output logic [TMO_W-1:0]             first_ts,
`endif
    output logic                         timeout_flag
);

    localparam int LEN_W = $clog2(PAT_MAX + 1);

    state_t             state_q, state_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               timeout_flag_q, timeout_flag_d;
    logic               match_q, match_d;
    logic               done_q, done_d;
`ifdef SEQ_SCAN_TSTAMP_EN
    logic [TMO_W-1:0]   ts_cnt_q, ts_cnt_d;
    logic [TMO_W-1:0]   first_ts_q, first_ts_d;
    logic               hit_seen_q, hit_seen_d;
`endif

    logic               w_hit;
    logic               w_shift;
    logic               w_clr;
    logic [LEN_W-1:0]   w_len_clamped;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [TMO_W-1:0]   w_tmo_inc;
    logic               w_tgt_hit;
    logic               w_tmo_hit;

    assign w_shift       = (state_q == ST_SCAN) && x_valid;
    assign w_len_clamped = LEN_W'(clamp_len(32'(cfg_len), PAT_MAX));
    assign w_cnt_inc     = (&match_cnt_q) ? match_cnt_q : match_cnt_q + 1'b1;
    assign w_tmo_inc     = tmo_cnt_q + 1'b1;
    // Wide compare so a saturated count never aliases onto the target
    assign w_tgt_hit     = (tgt_q != '0) &&
                           (({1'b0, match_cnt_q} + 1'b1) == {1'b0, tgt_q});
    assign w_tmo_hit     = (tmo_q != '0) && (w_tmo_inc == tmo_q);

    seq_pat_match #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_pat_match (
        .clk     (clk),
        .rst     (rst),
        .shift   (w_shift),
        .clr     (w_clr),
        .x       (x),
        .len     (len_q),
        .pattern (pat_q),
        .overlap (ovl_q),
        .hit     (w_hit)
    );

    // Next-state, shadow config and counter updates; abort beats hit beats timeout
    always_comb begin
        state_d        = state_q;
        pat_d          = pat_q;
        len_d          = len_q;
        ovl_d          = ovl_q;
        tgt_d          = tgt_q;
        tmo_d          = tmo_q;
        match_cnt_d    = match_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        timeout_flag_d = timeout_flag_q;
        match_d        = 1'b0;
        done_d         = 1'b0;
        w_clr          = 1'b0;
`ifdef SEQ_SCAN_TSTAMP_EN
        ts_cnt_d       = ts_cnt_q;
        first_ts_d     = first_ts_q;
        hit_seen_d     = hit_seen_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d          = cfg_pattern;
                    len_d          = w_len_clamped;
                    ovl_d          = cfg_overlap;
                    tgt_d          = cfg_target;
                    tmo_d          = cfg_timeout;
                    match_cnt_d    = '0;
                    tmo_cnt_d      = '0;
                    timeout_flag_d = 1'b0;
                    w_clr          = 1'b1;
`ifdef SEQ_SCAN_TSTAMP_EN
                    ts_cnt_d       = '0;
                    first_ts_d     = '0;
                    hit_seen_d     = 1'b0;
`endif
                    state_d        = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = abort ? ST_IDLE : ST_SCAN;
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef SEQ_SCAN_TSTAMP_EN
                    if (x_valid && !hit_seen_q) begin
                        ts_cnt_d = ts_cnt_q + 1'b1;
                        if (w_hit) begin
                            first_ts_d = ts_cnt_q + 1'b1;
                            hit_seen_d = 1'b1;
                        end
                    end
`endif
                    if (w_hit) begin
                        match_d     = 1'b1;
                        match_cnt_d = w_cnt_inc;
                        tmo_cnt_d   = '0;
                        if (w_tgt_hit) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else if (w_tmo_hit) begin
                        tmo_cnt_d      = w_tmo_inc;
                        timeout_flag_d = 1'b1;
                        done_d         = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        tmo_cnt_d = w_tmo_inc;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shadow config, counters and registered pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            pat_q          <= '0;
            len_q          <= '0;
            ovl_q          <= 1'b0;
            tgt_q          <= '0;
            tmo_q          <= '0;
            match_cnt_q    <= '0;
            tmo_cnt_q      <= '0;
            timeout_flag_q <= 1'b0;
            match_q        <= 1'b0;
            done_q         <= 1'b0;
`ifdef SEQ_SCAN_TSTAMP_EN
            ts_cnt_q       <= '0;
            first_ts_q     <= '0;
            hit_seen_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            pat_q          <= pat_d;
            len_q          <= len_d;
            ovl_q          <= ovl_d;
            tgt_q          <= tgt_d;
            tmo_q          <= tmo_d;
            match_cnt_q    <= match_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            timeout_flag_q <= timeout_flag_d;
            match_q        <= match_d;
            done_q         <= done_d;
`ifdef SEQ_SCAN_TSTAMP_EN
            ts_cnt_q       <= ts_cnt_d;
            first_ts_q     <= first_ts_d;
            hit_seen_q     <= hit_seen_d;
`endif
        end
    end

    assign busy         = (state_q == ST_ARM) || (state_q == ST_SCAN);
    assign match        = match_q;
    assign match_cnt    = match_cnt_q;
    assign done         = done_q;
    assign timeout_flag = timeout_flag_q;
`ifdef SEQ_SCAN_TSTAMP_EN
    assign first_ts     = first_ts_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_scan_ctrl
// Description : Scoreboard bench for seq_scan_ctrl. Stimulus pushes the
//               expected match/done events (with cycle stamp) into a queue;
//               a monitor pops and compares whenever match or done is seen.
//               Honours SEQ_SCAN_TSTAMP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_scan_ctrl;

    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 8;
    localparam int TMO_W   = 16;
    localparam int LEN_W   = $clog2(PAT_MAX + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic [TMO_W-1:0]   cfg_timeout;
    logic               start;
    logic               abort;
    logic               x;
    logic               x_valid;
    logic               busy;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               done;
    logic               timeout_flag;
`ifdef SEQ_SCAN_TSTAMP_EN
    logic [TMO_W-1:0]   first_ts;
`endif

    typedef struct {
        int c;
        bit m;
        bit d;
        int cnt;
        bit tf;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    seq_scan_ctrl #(
        .PAT_MAX (PAT_MAX),
        .CNT_W   (CNT_W),
        .TMO_W   (TMO_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .cfg_target   (cfg_target),
        .cfg_timeout  (cfg_timeout),
        .start        (start),
        .abort        (abort),
        .x            (x),
        .x_valid      (x_valid),
        .busy         (busy),
        .match        (match),
        .match_cnt    (match_cnt),
        .done         (done),
`ifdef SEQ_SCAN_TSTAMP_EN
        .first_ts     (first_ts),
`endif
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    // Cycle stamp used to pin expected events to an exact clock
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One input cycle; expected event (if any) becomes visible after this edge
    task automatic step(input bit xv, input bit xb, input bit ab, input bit st,
                        input bit em, input bit ed, input int ecnt, input bit etf);
        x_valid = xv;
        x       = xb;
        abort   = ab;
        start   = st;
        if (em || ed) q.push_back('{cyc + 1, em, ed, ecnt, etf});
        tick();
        x_valid = 1'b0;
        x       = 1'b0;
        abort   = 1'b0;
        start   = 1'b0;
    endtask

    // Load config, pulse start, pass the ARM cycle; returns with state in SCAN
    task automatic run_start(input logic [PAT_MAX-1:0] pat, input logic [LEN_W-1:0] len,
                             input bit ovl, input logic [CNT_W-1:0] tgt,
                             input logic [TMO_W-1:0] tmo);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_target  = tgt;
        cfg_timeout = tmo;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        chk("busy_in_arm", int'(busy), 1);
        tick();
    endtask

    initial begin
        rst = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; cfg_timeout = '0;
        start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;

        fork
            // Monitor: every match/done pulse must match the next scoreboard entry
            forever begin
                @(negedge clk);
                if (match || done) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_event: cyc=%0d match=%0b done=%0b cnt=%0d tflag=%0b expected none",
                                 cyc, match, done, match_cnt, timeout_flag);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        if (e.c != cyc || e.m != match || e.d != done ||
                            e.cnt != int'(match_cnt) || e.tf != timeout_flag) begin
                            bad++;
                            $display("FAIL event: got cyc=%0d m=%0b d=%0b cnt=%0d tf=%0b expected cyc=%0d m=%0b d=%0b cnt=%0d tf=%0b",
                                     cyc, match, done, match_cnt, timeout_flag,
                                     e.c, e.m, e.d, e.cnt, e.tf);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) tick();
        chk("rst_busy",  int'(busy), 0);
        chk("rst_match", int'(match), 0);
        chk("rst_cnt",   int'(match_cnt), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_tflag", int'(timeout_flag), 0);
        rst = 1'b1;
        tick();

        // 1010 overlapping, no target: matches after bits 4 and 6
        run_start(8'h0A, 4'd4, 1'b1, 8'd0, 16'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 2, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("t1_busy_after_abort", int'(busy), 0);
        chk("t1_cnt_held", int'(match_cnt), 2);
`ifdef SEQ_SCAN_TSTAMP_EN
        chk("t1_first_ts", int'(first_ts), 4);
`endif
        tick();
        chk("t1_q_empty", q.size(), 0);

        // 1010 non-overlapping: only one match
        run_start(8'h0A, 4'd4, 1'b0, 8'd0, 16'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("t2_cnt", int'(match_cnt), 1);
        tick();
        chk("t2_q_empty", q.size(), 0);

        // Target 2: second match and done together, then idle
        run_start(8'h0A, 4'd4, 1'b1, 8'd2, 16'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 2, 0);
        chk("t3_busy_in_done", int'(busy), 0);
        tick();
        chk("t3_busy_idle", int'(busy), 0);
        chk("t3_cnt_held", int'(match_cnt), 2);
        chk("t3_done_cleared", int'(done), 0);
        chk("t3_q_empty", q.size(), 0);

        // Timeout 5 with zeros; one idle cycle still counts toward timeout
        run_start(8'h0A, 4'd4, 1'b1, 8'd0, 16'd5);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 1);
        chk("t4_busy_in_done", int'(busy), 0);
        tick();
        chk("t4_tflag_sticky", int'(timeout_flag), 1);
        chk("t4_cnt", int'(match_cnt), 0);
`ifdef SEQ_SCAN_TSTAMP_EN
        chk("t4_first_ts", int'(first_ts), 0);
`endif
        chk("t4_q_empty", q.size(), 0);

        // Abort on the hit sample beats both hit and target
        run_start(8'h0A, 4'd4, 1'b1, 8'd1, 16'd0);
        chk("t5_tflag_cleared", int'(timeout_flag), 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        chk("t5_busy_after_abort", int'(busy), 0);
        tick();
        chk("t5_cnt", int'(match_cnt), 0);
        chk("t5_q_empty", q.size(), 0);

        // len 0 acts as len 1; start and config changes mid-run are ignored
        run_start(8'h01, 4'd0, 1'b1, 8'd3, 16'd0);
        cfg_pattern = 8'h00;
        cfg_target  = 8'd1;
        cfg_len     = 4'd4;
        step(1, 1, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0, 2, 0);
        chk("t6_still_busy", int'(busy), 1);
        step(1, 1, 0, 0, 1, 1, 3, 0);
        tick();
        chk("t6_cnt", int'(match_cnt), 3);
        chk("t6_q_empty", q.size(), 0);

        // Async reset right after a match pulse, then a clean run
        run_start(8'h0A, 4'd4, 1'b1, 8'd0, 16'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("t7_rst_match", int'(match), 0);
        chk("t7_rst_cnt",   int'(match_cnt), 0);
        chk("t7_rst_busy",  int'(busy), 0);
        chk("t7_rst_done",  int'(done), 0);
        #1;
        rst = 1'b1;
        tick();
        run_start(8'h0A, 4'd4, 1'b1, 8'd1, 16'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 1, 0);
        tick();
        chk("t7_busy_idle", int'(busy), 0);
        chk("t7_cnt", int'(match_cnt), 1);
        tick();
        chk("final_q_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
